// File: rtl/sace_pkg.sv
// -----------------------------------------------------------------------------
// sace_pkg
// Shared constants for the SystemACE sector read controller:
//   - register byte addresses on the low-level (ll) bus
//   - STATUS bit indices polled by the controller
//   - CONTROL / sector-command values
//   - controller state enum (also exported on the debug state port)
// -----------------------------------------------------------------------------
package sace_pkg;

  // Register byte addresses
  localparam logic [7:0] REG_STATUS  = 8'h04;
  localparam logic [7:0] REG_LBA_LO  = 8'h10;
  localparam logic [7:0] REG_LBA_HI  = 8'h12;
  localparam logic [7:0] REG_SECCMD  = 8'h14;
  localparam logic [7:0] REG_CONTROL = 8'h18;
  localparam logic [7:0] REG_DATABUF = 8'h40;

  // STATUS bit indices
  localparam int STAT_MPULOCK    = 1;
  localparam int STAT_DATABUFRDY = 5;
  localparam int STAT_CFCMDRDY   = 8;

  // CONTROL and sector-command values
  localparam logic [15:0] CTRL_LOCK_REQ  = 16'h0002;
  localparam logic [15:0] CTRL_RELEASE   = 16'h0000;
  localparam logic [15:0] CMD_READ_1SEC  = 16'h0301;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_LOCK      = 4'd1,
    S_LOCK_POLL = 4'd2,
    S_RDY_POLL  = 4'd3,
    S_LBA_LO    = 4'd4,
    S_LBA_HI    = 4'd5,
    S_CMD       = 4'd6,
    S_BUF_POLL  = 4'd7,
    S_BUF_RD    = 4'd8,
    S_REL       = 4'd9,
    S_FIN       = 4'd10
  } state_e;

endpackage

// File: rtl/sace_ll_issue.sv
// -----------------------------------------------------------------------------
// sace_ll_issue
// Single-outstanding issue/complete engine for the low-level register bus.
//
// Handshake: the requester holds req_i (with req_write_i/addr/wdata/isbuf
// stable) from the cycle it wants an access until the cycle cmp_o is high.
// A one-cycle llread/llwrite pulse is emitted only when req_i=1, llbusy=0 and
// no access is outstanding. A read completes on the first llavail=1 after its
// pulse; a write completes on the first llbusy=0 cycle at least two cycles
// after its pulse. cmp_o is high for exactly that completion cycle.
//
// Ports
//   clk_i, rst_ni                 clock, async active-low reset
//   req_i, req_write_i,
//   req_isbuf_i, req_addr_i,
//   req_wdata_i                   access request from the controller FSM
//   cmp_o                         completion pulse
//   llread_o, llwrite_o,
//   llwritedata_o, lladdr_o,
//   ll_isbuffer_o                 low-level request side
//   llavail_i, llbusy_i           low-level response side
// -----------------------------------------------------------------------------
module sace_ll_issue #(
  parameter int ADDR_W = 7
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_i,
  input  logic              req_write_i,
  input  logic              req_isbuf_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [15:0]       req_wdata_i,
  output logic              cmp_o,
  output logic              llread_o,
  output logic              llwrite_o,
  output logic [15:0]       llwritedata_o,
  output logic [ADDR_W-1:0] lladdr_o,
  output logic              ll_isbuffer_o,
  input  logic              llavail_i,
  input  logic              llbusy_i
);

  logic       out_q, out_d;   // an access is outstanding
  logic       wr_q,  wr_d;    // outstanding access is a write
  logic [1:0] age_q, age_d;   // cycles since the pulse, saturating at 2
  logic       fire;

  assign fire  = req_i & ~out_q & ~llbusy_i;
  assign cmp_o = out_q & (wr_q ? ((age_q == 2'd2) & ~llbusy_i) : llavail_i);

  always_comb begin
    out_d = out_q;
    wr_d  = wr_q;
    age_d = age_q;
    if (fire) begin
      out_d = 1'b1;
      wr_d  = req_write_i;
      age_d = 2'd1;
    end else if (out_q) begin
      if (cmp_o) out_d = 1'b0;
      if (age_q != 2'd2) age_d = age_q + 2'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_q <= 1'b0;
      wr_q  <= 1'b0;
      age_q <= 2'd0;
    end else begin
      out_q <= out_d;
      wr_q  <= wr_d;
      age_q <= age_d;
    end
  end

  // Address/data are driven from the held request, so they stay valid for
  // the whole access and drop to zero as soon as the FSM leaves a bus state.
  assign llread_o      = fire & ~req_write_i;
  assign llwrite_o     = fire &  req_write_i;
  assign lladdr_o      = req_i ? req_addr_i : '0;
  assign llwritedata_o = (req_i & req_write_i) ? req_wdata_i : '0;
  assign ll_isbuffer_o = req_i & req_isbuf_i & ~req_write_i;

endmodule

// File: rtl/systemace_sector_ctrl.sv
// -----------------------------------------------------------------------------
// systemace_sector_ctrl
// Reads one 512-byte sector from a SystemACE controller: takes the MPU lock,
// waits for CF command ready, programs the LBA, issues a one-sector read,
// drains 256 DATABUF words in bursts of 16 and releases the lock.
//
// Optional feature macro: SACE_POLL_TIMEOUT_EN
//   defined   -> each poll state gives up after POLL_LIMIT STATUS reads
//                without the awaited bit, releases the lock and pulses err
//   undefined -> polls wait forever, err is constant 0
//
// Ports
//   CLK, RST                      clock, async active-low reset
//   start, lba                    request (sampled in IDLE only) and sector LBA
//   busy, done, err               status; done/err are one-cycle pulses
//   sec_data, sec_valid           sector word stream
//   llread, llwrite, llwritedata,
//   lladdr, ll_isbuffer           low-level request side
//   llreaddata, llavail, llbusy   low-level response side
//   dbg_state                     current FSM state (sace_pkg::state_e)
// -----------------------------------------------------------------------------
module systemace_sector_ctrl
  import sace_pkg::*;
#(
  parameter int unsigned POLL_LIMIT = 20'hFFFFF,
  parameter int          LL_ADDR_W  = 7
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 start,
  input  logic [27:0]          lba,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [15:0]          sec_data,
  output logic                 sec_valid,
  output logic                 llread,
  output logic                 llwrite,
  output logic [15:0]          llwritedata,
  output logic [LL_ADDR_W-1:0] lladdr,
  output logic                 ll_isbuffer,
  input  logic [15:0]          llreaddata,
  input  logic                 llavail,
  input  logic                 llbusy,
  output logic [3:0]           dbg_state
);

  state_e      state_q, state_d;
  logic [27:0] lba_q, lba_d;
  logic [8:0]  word_cnt_q, word_cnt_d;  // 0..256 words delivered
  logic        done_q, done_d;

  logic        cmp;
  logic        req, req_write, req_isbuf;
  logic [7:0]  req_addr_b;
  logic [15:0] req_wdata;
  logic        poll_bit;     // awaited STATUS bit for the current poll state
  logic        timeout_hit;  // poll gave up on this completion
  logic        fail;         // current transfer is ending in error

  // ---------------------------------------------------------------------------
  // Bus request decode: one register access per bus-owning state
  // ---------------------------------------------------------------------------
  always_comb begin
    req        = 1'b1;
    req_write  = 1'b0;
    req_isbuf  = 1'b0;
    req_addr_b = REG_STATUS;
    req_wdata  = 16'h0000;
    unique case (state_q)
      S_LOCK:     begin req_write = 1'b1; req_addr_b = REG_CONTROL; req_wdata = CTRL_LOCK_REQ; end
      S_LOCK_POLL, S_RDY_POLL, S_BUF_POLL: req_addr_b = REG_STATUS;
      S_LBA_LO:   begin req_write = 1'b1; req_addr_b = REG_LBA_LO; req_wdata = lba_q[15:0]; end
      S_LBA_HI:   begin req_write = 1'b1; req_addr_b = REG_LBA_HI; req_wdata = {4'h0, lba_q[27:16]}; end
      S_CMD:      begin req_write = 1'b1; req_addr_b = REG_SECCMD; req_wdata = CMD_READ_1SEC; end
      S_BUF_RD:   begin req_addr_b = REG_DATABUF; req_isbuf = 1'b1; end
      S_REL:      begin req_write = 1'b1; req_addr_b = REG_CONTROL; req_wdata = CTRL_RELEASE; end
      default:    req = 1'b0;
    endcase
  end

  always_comb begin
    poll_bit = 1'b0;
    unique case (state_q)
      S_LOCK_POLL: poll_bit = llreaddata[STAT_MPULOCK];
      S_RDY_POLL:  poll_bit = llreaddata[STAT_CFCMDRDY];
      S_BUF_POLL:  poll_bit = llreaddata[STAT_DATABUFRDY];
      default:     poll_bit = 1'b0;
    endcase
  end

  sace_ll_issue #(.ADDR_W(LL_ADDR_W)) u_issue (
    .clk_i         (CLK),
    .rst_ni        (RST),
    .req_i         (req),
    .req_write_i   (req_write),
    .req_isbuf_i   (req_isbuf),
    .req_addr_i    (LL_ADDR_W'(req_addr_b)),
    .req_wdata_i   (req_wdata),
    .cmp_o         (cmp),
    .llread_o      (llread),
    .llwrite_o     (llwrite),
    .llwritedata_o (llwritedata),
    .lladdr_o      (lladdr),
    .ll_isbuffer_o (ll_isbuffer),
    .llavail_i     (llavail),
    .llbusy_i      (llbusy)
  );

  // ---------------------------------------------------------------------------
  // Main FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    lba_d      = lba_q;
    word_cnt_d = word_cnt_q;
    done_d     = 1'b0;
    unique case (state_q)
      S_IDLE: if (start) begin
        lba_d      = lba;
        word_cnt_d = 9'd0;
        state_d    = S_LOCK;
      end
      S_LOCK:      if (cmp) state_d = S_LOCK_POLL;
      S_LOCK_POLL: if (cmp) begin
        if (poll_bit)         state_d = S_RDY_POLL;
        else if (timeout_hit) state_d = S_REL;
      end
      S_RDY_POLL:  if (cmp) begin
        if (poll_bit)         state_d = S_LBA_LO;
        else if (timeout_hit) state_d = S_REL;
      end
      S_LBA_LO:    if (cmp) state_d = S_LBA_HI;
      S_LBA_HI:    if (cmp) state_d = S_CMD;
      S_CMD:       if (cmp) state_d = S_BUF_POLL;
      S_BUF_POLL:  if (cmp) begin
        if (poll_bit)         state_d = S_BUF_RD;
        else if (timeout_hit) state_d = S_REL;
      end
      S_BUF_RD:    if (cmp) begin
        word_cnt_d = word_cnt_q + 9'd1;
        // Word 256 ends the sector; every 16th word re-checks DATABUFRDY.
        if (word_cnt_q == 9'd255)          state_d = S_REL;
        else if (word_cnt_q[3:0] == 4'hF)  state_d = S_BUF_POLL;
      end
      S_REL:       if (cmp) begin
        state_d = S_FIN;
        done_d  = ~fail;
      end
      S_FIN:       state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= S_IDLE;
      lba_q      <= 28'h0;
      word_cnt_q <= 9'd0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      lba_q      <= lba_d;
      word_cnt_q <= word_cnt_d;
      done_q     <= done_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Optional poll timeout
  // ---------------------------------------------------------------------------
`ifdef SACE_POLL_TIMEOUT_EN
  localparam int PW = $clog2(POLL_LIMIT + 1);

  logic [PW-1:0] poll_cnt_q;
  logic          fail_q;
  logic          err_q;
  logic          in_poll;

  assign in_poll     = (state_q == S_LOCK_POLL) || (state_q == S_RDY_POLL) ||
                       (state_q == S_BUF_POLL);
  assign timeout_hit = in_poll & cmp & ~poll_bit & (poll_cnt_q == PW'(POLL_LIMIT - 1));
  assign fail        = fail_q;
  assign err         = err_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      poll_cnt_q <= '0;
      fail_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      // Counter restarts whenever a poll state is left (success or give-up).
      if (!in_poll || (state_d != state_q)) poll_cnt_q <= '0;
      else if (cmp)                         poll_cnt_q <= poll_cnt_q + PW'(1);

      if ((state_q == S_IDLE) && start) fail_q <= 1'b0;
      else if (timeout_hit)             fail_q <= 1'b1;

      err_q <= (state_q == S_REL) & cmp & fail_q;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign fail        = 1'b0;
  assign err         = 1'b0;

  // POLL_LIMIT is only consumed by the timeout build.
  if (POLL_LIMIT == 0) begin : g_no_poll_limit
  end
`endif

  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  // Word stream is presented on the completion cycle of each DATABUF read.
  assign sec_valid = cmp & (state_q == S_BUF_RD);
  assign sec_data  = sec_valid ? llreaddata : 16'h0000;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_systemace_sector_ctrl.sv
// -----------------------------------------------------------------------------
// tb_systemace_sector_ctrl
// Directed bench: a behavioural SystemACE register model answers ll reads
// one cycle after the pulse, logs writes, and serves STATUS/DATABUF values.
// -----------------------------------------------------------------------------
module tb_systemace_sector_ctrl;

`ifdef SACE_POLL_TIMEOUT_EN
  localparam int unsigned TB_POLL_LIMIT = 8;
`else
  localparam int unsigned TB_POLL_LIMIT = 20'hFFFFF;
`endif

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic        CLK = 1'b0;
  logic        RST;
  logic        start;
  logic [27:0] lba;
  logic        busy, done, err;
  logic [15:0] sec_data;
  logic        sec_valid;
  logic        llread, llwrite;
  logic [15:0] llwritedata;
  logic [6:0]  lladdr;
  logic        ll_isbuffer;
  logic [15:0] llreaddata;
  logic        llavail;
  logic        llbusy;
  logic [3:0]  dbg_state;

  always #5 CLK = ~CLK;

  systemace_sector_ctrl #(.POLL_LIMIT(TB_POLL_LIMIT), .LL_ADDR_W(7)) dut (
    .CLK(CLK), .RST(RST), .start(start), .lba(lba),
    .busy(busy), .done(done), .err(err),
    .sec_data(sec_data), .sec_valid(sec_valid),
    .llread(llread), .llwrite(llwrite), .llwritedata(llwritedata),
    .lladdr(lladdr), .ll_isbuffer(ll_isbuffer),
    .llreaddata(llreaddata), .llavail(llavail), .llbusy(llbusy),
    .dbg_state(dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Register model (updates just after each rising edge)
  // ---------------------------------------------------------------------------
  int          lock_wait, lock_reads, post_lock_reads, buf_run;
  bit          lock_granted, rdy_ok, pend;
  logic [15:0] buf_ctr, pend_data;
  logic [6:0]  wr_addr_q[$];
  logic [15:0] wr_data_q[$];

  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      pend       = 1'b0;
      llavail    = 1'b0;
      llreaddata = 16'h0000;
    end else begin
      #1;
      if (llavail) begin
        llavail    = 1'b0;
        llreaddata = 16'h0000;
      end
      if (pend) begin
        llavail    = 1'b1;
        llreaddata = pend_data;
        pend       = 1'b0;
      end
      if (llread) begin
        pend = 1'b1;
        if (lladdr == 7'h04) begin
          check_eq("isbuf_on_status", ll_isbuffer, 1'b0);
          if (buf_run != 0) begin
            check_eq("databuf_burst_len", buf_run, 16);
            buf_run = 0;
          end
          if (!lock_granted) begin
            lock_reads++;
            if (lock_reads > lock_wait) lock_granted = 1'b1;
          end else begin
            post_lock_reads++;
          end
          pend_data = {7'h0, (lock_granted && rdy_ok), 2'b0, lock_granted,
                       3'b0, lock_granted, 1'b0};
        end else if (lladdr == 7'h40) begin
          check_eq("isbuf_on_databuf", ll_isbuffer, 1'b1);
          buf_run++;
          pend_data = buf_ctr;
          buf_ctr   = buf_ctr + 16'd1;
        end else begin
          check_eq("read_addr_legal", lladdr, 7'h04);
          pend_data = 16'hDEAD;
        end
      end
      if (llwrite) begin
        wr_addr_q.push_back(lladdr);
        wr_data_q.push_back(llwritedata);
        if (lladdr == 7'h18 && llwritedata == 16'h0000 && buf_run != 0) begin
          check_eq("databuf_burst_len", buf_run, 16);
          buf_run = 0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Scoreboard / monitors (sample on falling edge)
  // ---------------------------------------------------------------------------
  logic [15:0] exp_q[$];
  int sec_cnt = 0, done_cnt = 0, err_cnt = 0;

  always @(negedge CLK) begin
    if (RST) begin
      if (sec_valid) begin
        sec_cnt++;
        check_eq("sec_expected", (exp_q.size() != 0), 1'b1);
        if (exp_q.size() != 0) check_eq("sec_data", sec_data, exp_q.pop_front());
      end
      if (done) done_cnt++;
      if (err)  err_cnt++;
      if (done || err) check_eq("done_err_exclusive", done & err, 1'b0);
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic prep_model(input int lock_delay, input bit rdy_en, input bit fill);
    lock_wait       = lock_delay;
    rdy_ok          = rdy_en;
    lock_reads      = 0;
    lock_granted    = 1'b0;
    post_lock_reads = 0;
    buf_run         = 0;
    buf_ctr         = 16'h0000;
    wr_addr_q.delete();
    wr_data_q.delete();
    exp_q.delete();
    if (fill) for (int i = 0; i < 256; i++) exp_q.push_back(16'(i));
  endtask

  task automatic pulse_start(input logic [27:0] l);
    @(negedge CLK);
    lba   = l;
    start = 1'b1;
    #1;
    check_eq("no_ll_pulse_on_start_cycle", {30'h0, llread, llwrite}, 32'h0);
    @(negedge CLK);
    start = 1'b0;
  endtask

  task automatic wait_end(input string name, output bit ended);
    int base;
    base  = done_cnt + err_cnt;
    ended = 1'b0;
    for (int c = 0; c < 20000 && !ended; c++) begin
      @(negedge CLK);
      #1;
      if (done_cnt + err_cnt != base) ended = 1'b1;
    end
    check_eq({name, "_ended"}, ended, 1'b1);
  endtask

  task automatic check_writes(input string name, input logic [27:0] l, input bit exp_err);
    logic [6:0]  ea[$];
    logic [15:0] ed[$];
    if (exp_err) begin
      ea = '{7'h18, 7'h18};
      ed = '{16'h0002, 16'h0000};
    end else begin
      ea = '{7'h18, 7'h10, 7'h12, 7'h14, 7'h18};
      ed = '{16'h0002, l[15:0], {4'h0, l[27:16]}, 16'h0301, 16'h0000};
    end
    check_eq({name, "_write_count"}, wr_addr_q.size(), ea.size());
    for (int i = 0; i < ea.size() && i < wr_addr_q.size(); i++) begin
      check_eq($sformatf("%s_wr%0d_addr", name, i), wr_addr_q[i], ea[i]);
      check_eq($sformatf("%s_wr%0d_data", name, i), wr_data_q[i], ed[i]);
    end
  endtask

  task automatic do_sector(input string name, input logic [27:0] l, input int lock_delay,
                           input bit rdy_en, input bit exp_err);
    int bd, be, bs;
    bit ended;
    prep_model(lock_delay, rdy_en, !exp_err);
    bd = done_cnt; be = err_cnt; bs = sec_cnt;
    pulse_start(l);
    wait_end(name, ended);
    repeat (2) @(negedge CLK);
    #1;
    check_eq({name, "_done_pulses"}, done_cnt - bd, exp_err ? 0 : 1);
    check_eq({name, "_err_pulses"},  err_cnt - be,  exp_err ? 1 : 0);
    check_eq({name, "_sec_valid_count"}, sec_cnt - bs, exp_err ? 0 : 256);
    check_eq({name, "_exp_q_drained"}, exp_q.size(), 0);
    check_eq({name, "_idle_after"}, busy, 1'b0);
    check_writes(name, l, exp_err);
  endtask

  task automatic check_outputs_zero(input string name);
    check_eq({name, "_busy"},        busy,        1'b0);
    check_eq({name, "_done"},        done,        1'b0);
    check_eq({name, "_err"},         err,         1'b0);
    check_eq({name, "_sec_valid"},   sec_valid,   1'b0);
    check_eq({name, "_sec_data"},    sec_data,    16'h0000);
    check_eq({name, "_llread"},      llread,      1'b0);
    check_eq({name, "_llwrite"},     llwrite,     1'b0);
    check_eq({name, "_llwritedata"}, llwritedata, 16'h0000);
    check_eq({name, "_lladdr"},      lladdr,      7'h00);
    check_eq({name, "_ll_isbuffer"}, ll_isbuffer, 1'b0);
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    int bd, bs;
    bit ended;
    RST        = 1'b0;
    start      = 1'b0;
    lba        = 28'h0;
    llbusy     = 1'b0;
    llavail    = 1'b0;
    llreaddata = 16'h0000;
    prep_model(0, 1'b1, 1'b0);

    repeat (3) @(negedge CLK);
    check_outputs_zero("reset");
    RST = 1'b1;
    repeat (2) @(negedge CLK);

    // Basic sector, immediate lock/ready/bufrdy, incrementing DATABUF data
    do_sector("basic", 28'h0000123, 0, 1'b1, 1'b0);
    check_eq("basic_lock_reads", lock_reads, 1);

    // Lock withheld for 50 polls; different LBA pattern
    do_sector("lockwait", 28'hABCDEF1, 50, 1'b1, 1'b0);
    check_eq("lockwait_lock_reads", lock_reads, 51);

`ifdef SACE_POLL_TIMEOUT_EN
    // CFCMDRDY never set: 8 ready polls, lock released, err pulse
    do_sector("timeout", 28'h0000001, 0, 1'b0, 1'b1);
    check_eq("timeout_rdy_reads", post_lock_reads, 8);
`endif

    // Reset in the middle of the DATABUF drain
    prep_model(0, 1'b1, 1'b1);
    bs = sec_cnt;
    pulse_start(28'h0000777);
    ended = 1'b0;
    for (int c = 0; c < 20000 && !ended; c++) begin
      @(negedge CLK);
      #1;
      if (sec_cnt - bs >= 100) ended = 1'b1;
    end
    check_eq("midreset_reached_word100", ended, 1'b1);
    #1;
    RST = 1'b0;
    #1;
    check_outputs_zero("midreset");
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    do_sector("after_reset", 28'h0000456, 0, 1'b1, 1'b0);

    // start while busy and on the FIN-to-IDLE cycle must be ignored
    prep_model(0, 1'b1, 1'b1);
    bd = done_cnt;
    bs = sec_cnt;
    pulse_start(28'h0000321);
    repeat (5) @(negedge CLK);
    lba = 28'h0FFFFFF; start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    repeat (300) @(negedge CLK);
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    ended = 1'b0;
    for (int c = 0; c < 20000 && !ended; c++) begin
      @(negedge CLK);
      #1;
      if (done_cnt != bd) ended = 1'b1;
    end
    check_eq("busystart_ended", ended, 1'b1);
    start = 1'b1;  // lands in the FIN cycle
    @(negedge CLK);
    start = 1'b0;
    repeat (20) @(negedge CLK);
    #1;
    check_eq("busystart_done_pulses", done_cnt - bd, 1);
    check_eq("busystart_sec_count", sec_cnt - bs, 256);
    check_eq("busystart_idle", busy, 1'b0);
    check_writes("busystart", 28'h0000321, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/systemace_sector_ctrl.md
SYSTEMACE_SECTOR_CTRL -- requirements
Module: systemace_sector_ctrl

Interface
REQ-001 SHALL have parameter POLL_LIMIT, default 20'hFFFFF, max STATUS polls per wait before error.
REQ-002 SHALL have parameter LL_ADDR_W, default 7, width of lladdr.
REQ-003 SHALL have port CLK  input  1  sole clock; all logic rising-edge.
REQ-004 SHALL have port RST  input  1  asynchronous active-low reset.
REQ-005 SHALL have port start  input  1  one-cycle request, sampled only in IDLE.
REQ-006 SHALL have port lba  input  28  sector LBA, captured with start.
REQ-007 SHALL have ports busy, done, err  output  1 each  status; done/err are one-cycle pulses.
REQ-008 SHALL have ports sec_data (output 16) and sec_valid (output 1)  sector word stream.
REQ-009 SHALL have ports llread, llwrite (output 1), llwritedata (output 16), lladdr (output LL_ADDR_W), ll_isbuffer (output 1)  low-level request side.
REQ-010 SHALL have ports llreaddata (input 16), llavail (input 1), llbusy (input 1)  low-level response side.

Function
REQ-011 SHALL issue at most one ll access at a time; llread/llwrite are one-cycle pulses, asserted only when llbusy=0 and no access is outstanding.
REQ-012 A read SHALL complete on the first llavail=1 after its pulse; a write SHALL complete on the first cycle with llbusy=0 at least 2 cycles after its pulse.
REQ-013 ll_isbuffer SHALL be 1 only during DATABUF reads (byte addr 0x40), else 0.
REQ-014 States: IDLE, LOCK (write CONTROL 0x18 = 0x0002), LOCK_POLL (read STATUS 0x04 until bit1 MPULOCK), RDY_POLL (until bit8 CFCMDRDY), LBA_LO (write 0x10 = lba[15:0]), LBA_HI (write 0x12 = {4'h0, lba[27:16]}), CMD (write 0x14 = 0x0301), BUF_POLL (until bit5 DATABUFRDY), BUF_RD (16 DATABUF reads), REL (write CONTROL = 0x0000), FIN.
REQ-015 Transitions SHALL be strictly in REQ-014 order; BUF_RD returns to BUF_POLL until 256 words total, then REL.
REQ-016 Each DATABUF read completion SHALL drive sec_valid=1 for one cycle with sec_data = llreaddata on the same cycle.
REQ-017 Word counter SHALL be 9 bits, 0..256; exactly 256 sec_valid pulses per successful sector, none on error.
REQ-018 busy SHALL be 1 in every state except IDLE; start while busy is ignored.
REQ-019 FIN SHALL pulse done (success) or err (failure) for one cycle and return to IDLE next cycle; done and err never both 1.
REQ-020 start on the FIN-to-IDLE cycle SHALL NOT be accepted; earliest accepted start is first cycle in IDLE.

Reset
REQ-021 RST low SHALL force IDLE, counters 0, and all outputs 0 (llwritedata 16'h0000, lladdr 0) immediately, regardless of outstanding ll access.
REQ-022 After reset release, first ll pulse SHALL occur no earlier than 1 cycle after an accepted start.

Configuration
REQ-023 Macro SACE_POLL_TIMEOUT_EN: when defined, each poll state counts STATUS reads; at POLL_LIMIT without the awaited bit, SHALL go to REL (release lock) then FIN with err=1.
REQ-024 Without SACE_POLL_TIMEOUT_EN, polls SHALL wait indefinitely, err is tied 0, and no poll counter is instantiated.

Structure
REQ-025 Package sace_pkg SHALL hold register byte addresses (0x04, 0x10, 0x12, 0x14, 0x18, 0x40), status bit indices, command/control constants and the state enum.
REQ-026 One sub-module sace_ll_issue SHALL own the single-outstanding issue/complete handshake of REQ-011/012; FSM and counters stay in the top.

Verification
REQ-027 start, lba=28'h0000123, model lock/ready/bufrdy immediate -> writes 0x18=0x0002, 0x10=0x0123, 0x12=0x0000, 0x14=0x0301, 0x18=0x0000 in order; 256 sec_valid; one done pulse.
REQ-028 Model DATABUF returns incrementing 0x0000..0x00FF -> sec_data matches in order, 16 DATABUF reads between each BUF_POLL.
REQ-029 MPULOCK withheld 50 polls then set -> LOCK_POLL issues 51 STATUS reads, then continues normally.
REQ-030 With SACE_POLL_TIMEOUT_EN, POLL_LIMIT=8, CFCMDRDY never set -> 8 RDY_POLL reads, CONTROL=0x0000 written, err pulse, no sec_valid.
REQ-031 RST low mid-BUF_RD (word 100) -> all outputs 0 same cycle; new start after release yields full 256-word sector.
REQ-032 start pulsed while busy and on FIN-to-IDLE cycle -> ignored; exactly one sector transfer and one done.
